// File: rtl/arch_map_pkg.sv
// Shared types and default sizing for the committed architectural map and its
// recovery streamer.
package arch_map_pkg;

   localparam int N_WAY_DEF   = 3;
   localparam int N_ARCH_DEF  = 32;
   localparam int TAG_W_DEF   = 6;
   localparam int N_RD_DEF    = 2;
   localparam int RECOV_W_DEF = 8;
   localparam int ARCH_W_DEF  = $clog2(N_ARCH_DEF);

   typedef struct packed {
      logic                  valid;
      logic [ARCH_W_DEF-1:0] arch;
      logic [TAG_W_DEF-1:0]  tag;
   } ARCH_MAP_RET_PACKET;

   typedef struct packed {
      logic [ARCH_W_DEF-1:0]            base;
      logic [RECOV_W_DEF*TAG_W_DEF-1:0] tags;
   } ARCH_MAP_RECOV_BEAT;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } recov_state_e;

endpackage

// File: rtl/arch_map_recover_fsm.sv
// Recovery streamer control: walks recov_base across the map one beat per
// valid/ready handshake, then pulses done for a single cycle.
module arch_map_recover_fsm
   import arch_map_pkg::*;
#(
   parameter int N_ARCH  = N_ARCH_DEF,
   parameter int RECOV_W = RECOV_W_DEF,
   parameter int ARCH_W  = $clog2(N_ARCH)
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              recover_req,
   input  logic              recov_ready,
   output logic              recov_valid,
   output logic [ARCH_W-1:0] recov_base,
   output logic              recov_done,
   output logic              busy
);

   localparam logic [ARCH_W-1:0] LAST_BASE = ARCH_W'(N_ARCH - RECOV_W);
   localparam logic [ARCH_W-1:0] BEAT_STEP = ARCH_W'(RECOV_W);

   recov_state_e      state_reg, state_next;
   logic [ARCH_W-1:0] base_reg, base_next;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         base_reg  <= '0;
      end else begin
         state_reg <= state_next;
         base_reg  <= base_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      base_next  = base_reg;
      case (state_reg)
         IDLE: begin
            base_next = '0;
            if (recover_req) state_next = STREAM;
         end
         STREAM: begin
            if (recov_ready) begin
               if (base_reg == LAST_BASE) begin
                  state_next = DONE;
                  base_next  = '0;
               end else begin
                  base_next = base_reg + BEAT_STEP;
               end
            end
         end
         DONE: begin
            // A request landing here is dropped; the next one is taken from IDLE.
            state_next = IDLE;
            base_next  = '0;
         end
         default: begin
            state_next = IDLE;
            base_next  = '0;
         end
      endcase
   end

   assign recov_valid = (state_reg == STREAM);
   assign recov_done  = (state_reg == DONE);
   assign busy        = (state_reg == STREAM) || (state_reg == DONE);
   assign recov_base  = base_reg;

endmodule

// File: rtl/arch_map_table.sv
// Committed arch-to-physical map: applies retire bundles, releases overwritten
// tags, serves read ports and streams the whole map out on recovery.
module arch_map_table
   import arch_map_pkg::*;
#(
   parameter int N_WAY   = N_WAY_DEF,
   parameter int N_ARCH  = N_ARCH_DEF,
   parameter int TAG_W   = TAG_W_DEF,
   parameter int N_RD    = N_RD_DEF,
   parameter int RECOV_W = RECOV_W_DEF,
   parameter int ARCH_W  = $clog2(N_ARCH)
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_WAY-1:0]         ret_valid,
   input  logic [N_WAY*ARCH_W-1:0]  ret_arch,
   input  logic [N_WAY*TAG_W-1:0]   ret_tag,
   output logic [N_WAY-1:0]         free_valid,
   output logic [N_WAY*TAG_W-1:0]   free_tag,
   input  logic [N_RD*ARCH_W-1:0]   rd_arch,
   output logic [N_RD*TAG_W-1:0]    rd_tag,
   input  logic                     recover_req,
   output logic                     recov_valid,
   input  logic                     recov_ready,
   output logic [ARCH_W-1:0]        recov_base,
   output logic [RECOV_W*TAG_W-1:0] recov_tags,
   output logic                     recov_done,
   output logic                     busy
);

   logic [TAG_W-1:0]  map_reg [N_ARCH];
   logic [ARCH_W-1:0] lane_arch [N_WAY];
   logic [TAG_W-1:0]  lane_tag [N_WAY];
   logic [TAG_W-1:0]  old_tag [N_WAY];
   logic [N_WAY-1:0]  lane_wr;
   logic [N_WAY-1:0]  free_valid_reg;
   logic [TAG_W-1:0]  free_tag_reg [N_WAY];

   arch_map_recover_fsm #(
      .N_ARCH  (N_ARCH),
      .RECOV_W (RECOV_W),
      .ARCH_W  (ARCH_W)
   ) u_recover_fsm (
      .clock       (clock),
      .reset       (reset),
      .recover_req (recover_req),
      .recov_ready (recov_ready),
      .recov_valid (recov_valid),
      .recov_base  (recov_base),
      .recov_done  (recov_done),
      .busy        (busy)
   );

   // Arch 0 is hardwired and retires are frozen while the map is being streamed.
   generate
      for (genvar gi = 0; gi < N_WAY; gi++) begin : g_lane
         assign lane_arch[gi] = ret_arch[gi*ARCH_W +: ARCH_W];
         assign lane_tag[gi]  = ret_tag[gi*TAG_W +: TAG_W];
         assign lane_wr[gi]   = ret_valid[gi] && (lane_arch[gi] != '0) && !busy;
         assign free_tag[gi*TAG_W +: TAG_W] = free_tag_reg[gi];
      end
   endgenerate

   // The tag a lane displaces is the nearest older same-register write in the bundle.
   always_comb begin
      for (int k = 0; k < N_WAY; k++) begin
         old_tag[k] = map_reg[lane_arch[k]];
         for (int j = 0; j < k; j++) begin
            if (lane_wr[j] && (lane_arch[j] == lane_arch[k])) old_tag[k] = lane_tag[j];
         end
      end
   end

   // Later lanes are assigned last, so the youngest writer of a register wins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_ARCH; i++) map_reg[i] <= TAG_W'(i + 1);
      end else begin
         for (int k = 0; k < N_WAY; k++) begin
            if (lane_wr[k]) map_reg[lane_arch[k]] <= lane_tag[k];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         free_valid_reg <= '0;
         for (int k = 0; k < N_WAY; k++) free_tag_reg[k] <= '0;
      end else begin
         free_valid_reg <= lane_wr;
         for (int k = 0; k < N_WAY; k++) free_tag_reg[k] <= lane_wr[k] ? old_tag[k] : '0;
      end
   end

   assign free_valid = free_valid_reg;

   generate
      for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
         assign rd_tag[gi*TAG_W +: TAG_W] = map_reg[rd_arch[gi*ARCH_W +: ARCH_W]];
      end
      for (genvar gi = 0; gi < RECOV_W; gi++) begin : g_beat
         assign recov_tags[gi*TAG_W +: TAG_W] = map_reg[recov_base + ARCH_W'(gi)];
      end
   endgenerate

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset && busy) begin
         assert (ret_valid == '0)
            else $warning("arch_map_table: ret_valid asserted during recovery is ignored");
      end
   end
`endif

endmodule

// File: tb/tb_arch_map_table.sv
// Randomized bench for arch_map_table against a sequential map model.
module tb_arch_map_table;
   import arch_map_pkg::*;

   localparam int N_WAY   = 3;
   localparam int N_ARCH  = 32;
   localparam int TAG_W   = 6;
   localparam int N_RD    = 2;
   localparam int RECOV_W = 8;
   localparam int ARCH_W  = 5;
   localparam int N_BEATS = N_ARCH / RECOV_W;

   logic                     clock = 1'b0;
   logic                     reset;
   logic [N_WAY-1:0]         ret_valid;
   logic [N_WAY*ARCH_W-1:0]  ret_arch;
   logic [N_WAY*TAG_W-1:0]   ret_tag;
   logic [N_WAY-1:0]         free_valid;
   logic [N_WAY*TAG_W-1:0]   free_tag;
   logic [N_RD*ARCH_W-1:0]   rd_arch;
   logic [N_RD*TAG_W-1:0]    rd_tag;
   logic                     recover_req;
   logic                     recov_valid;
   logic                     recov_ready;
   logic [ARCH_W-1:0]        recov_base;
   logic [RECOV_W*TAG_W-1:0] recov_tags;
   logic                     recov_done;
   logic                     busy;

   always #5 clock = ~clock;

   arch_map_table #(
      .N_WAY (N_WAY), .N_ARCH (N_ARCH), .TAG_W (TAG_W), .N_RD (N_RD), .RECOV_W (RECOV_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ret_valid   (ret_valid),
      .ret_arch    (ret_arch),
      .ret_tag     (ret_tag),
      .free_valid  (free_valid),
      .free_tag    (free_tag),
      .rd_arch     (rd_arch),
      .rd_tag      (rd_tag),
      .recover_req (recover_req),
      .recov_valid (recov_valid),
      .recov_ready (recov_ready),
      .recov_base  (recov_base),
      .recov_tags  (recov_tags),
      .recov_done  (recov_done),
      .busy        (busy)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   logic [TAG_W-1:0]   model_map [N_ARCH];
   ARCH_MAP_RET_PACKET bundle [N_WAY];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_ARCH; i++) model_map[i] = TAG_W'(i + 1);
   endtask

   function automatic logic [RECOV_W*TAG_W-1:0] model_beat(input int b);
      logic [RECOV_W*TAG_W-1:0] r;
      r = '0;
      for (int j = 0; j < RECOV_W; j++) r[j*TAG_W +: TAG_W] = model_map[b*RECOV_W + j];
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_bundle();
      for (int k = 0; k < N_WAY; k++) begin
         ret_valid[k]                   = bundle[k].valid;
         ret_arch[k*ARCH_W +: ARCH_W]   = bundle[k].arch;
         ret_tag[k*TAG_W +: TAG_W]      = bundle[k].tag;
      end
   endtask

   task automatic random_bundle();
      for (int k = 0; k < N_WAY; k++) begin
         bundle[k].valid = 1'($urandom_range(0, 1));
         bundle[k].arch  = ($urandom_range(0, 1) == 1) ? ARCH_W'($urandom_range(0, 3))
                                                        : ARCH_W'($urandom_range(0, N_ARCH - 1));
         bundle[k].tag   = TAG_W'($urandom_range(1, 63));
      end
   endtask

   // Lanes are applied one after another: each lane frees whatever the map held
   // at that point, which is exactly the nearest-older-writer rule.
   task automatic retire_step();
      logic [N_WAY-1:0] exp_fv;
      logic [TAG_W-1:0] exp_ft [N_WAY];
      drive_bundle();
      for (int k = 0; k < N_WAY; k++) begin
         exp_fv[k] = 1'b0;
         exp_ft[k] = '0;
         if (bundle[k].valid && bundle[k].arch != 0) begin
            exp_fv[k] = 1'b1;
            exp_ft[k] = model_map[bundle[k].arch];
            model_map[bundle[k].arch] = bundle[k].tag;
         end
      end
      tick();
      ret_valid = '0;
      check("free_valid", 64'(free_valid), 64'(exp_fv));
      for (int k = 0; k < N_WAY; k++)
         if (exp_fv[k]) check($sformatf("free_tag%0d", k), 64'(free_tag[k*TAG_W +: TAG_W]), 64'(exp_ft[k]));
      $display("[TB] retire v=%b arch=%0d/%0d/%0d tag=%0d/%0d/%0d free_valid=%b",
               ret_valid, bundle[0].arch, bundle[1].arch, bundle[2].arch,
               bundle[0].tag, bundle[1].tag, bundle[2].tag, free_valid);
   endtask

   task automatic check_rd(input int a0, input int a1);
      rd_arch = {ARCH_W'(a1), ARCH_W'(a0)};
      #1;
      check($sformatf("rd0[%0d]", a0), 64'(rd_tag[0 +: TAG_W]), 64'(model_map[a0]));
      check($sformatf("rd1[%0d]", a1), 64'(rd_tag[TAG_W +: TAG_W]), 64'(model_map[a1]));
   endtask

   task automatic check_all_map();
      for (int i = 0; i < N_ARCH; i++) check_rd(i, N_ARCH - 1 - i);
   endtask

   initial begin
      int hs, guard;
      logic v_before, stalled;
      logic [ARCH_W-1:0] prev_base;
      logic [RECOV_W*TAG_W-1:0] prev_tags;

      reset = 1'b0; ret_valid = '0; ret_arch = '0; ret_tag = '0; rd_arch = '0;
      recover_req = 1'b0; recov_ready = 1'b0;
      for (int k = 0; k < N_WAY; k++) bundle[k] = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_free_valid", 64'(free_valid), 64'd0);
      check("rst_free_tag", 64'(free_tag), 64'd0);
      check("rst_recov_valid", 64'(recov_valid), 64'd0);
      check("rst_recov_base", 64'(recov_base), 64'd0);
      check("rst_recov_done", 64'(recov_done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      tick();
      check_all_map();
      $display("[TB] reset map checked");

      // Single-lane retire.
      bundle[0] = '{valid: 1'b1, arch: 5'd5, tag: 6'd40};
      retire_step();
      check("dir1_free_valid", 64'(free_valid), 64'b001);
      check("dir1_free_tag0", 64'(free_tag[0 +: TAG_W]), 64'd6);
      rd_arch = {ARCH_W'(0), ARCH_W'(5)};
      #1;
      check("dir1_rd5", 64'(rd_tag[0 +: TAG_W]), 64'd40);

      // Same register in two lanes plus an arch-0 lane.
      bundle[0] = '{valid: 1'b1, arch: 5'd3, tag: 6'd33};
      bundle[1] = '{valid: 1'b1, arch: 5'd3, tag: 6'd34};
      bundle[2] = '{valid: 1'b1, arch: 5'd0, tag: 6'd50};
      retire_step();
      check("dir2_free_valid", 64'(free_valid), 64'b011);
      check("dir2_free_tag0", 64'(free_tag[0 +: TAG_W]), 64'd4);
      check("dir2_free_tag1", 64'(free_tag[TAG_W +: TAG_W]), 64'd33);
      rd_arch = {ARCH_W'(0), ARCH_W'(3)};
      #1;
      check("dir2_rd3", 64'(rd_tag[0 +: TAG_W]), 64'd34);

      for (int n = 0; n < 60; n++) begin
         random_bundle();
         retire_step();
         check_rd($urandom_range(0, N_ARCH - 1), $urandom_range(0, 3));
      end

      // Retire and recovery in the same cycle, ready tied high.
      bundle[0] = '{valid: 1'b1, arch: 5'd7, tag: 6'd45};
      bundle[1] = '0;
      bundle[2] = '0;
      recover_req = 1'b1;
      recov_ready = 1'b1;
      retire_step();
      recover_req = 1'b0;
      for (int b = 0; b < N_BEATS; b++) begin
         check("fast_valid", 64'(recov_valid), 64'd1);
         check("fast_busy", 64'(busy), 64'd1);
         check("fast_base", 64'(recov_base), 64'(b * RECOV_W));
         check("fast_tags", 64'(recov_tags), 64'(model_beat(b)));
         if (b == 0) check("fast_entry7", 64'(recov_tags[7*TAG_W +: TAG_W]), 64'd45);
         $display("[TB] beat base=%0d tags=0x%0h", recov_base, recov_tags);
         tick();
      end
      check("fast_done", 64'(recov_done), 64'd1);
      check("fast_done_valid", 64'(recov_valid), 64'd0);
      recover_req = 1'b1;
      tick();
      recover_req = 1'b0;
      recov_ready = 1'b0;
      check("done_pulse_len", 64'(recov_done), 64'd0);
      check("req_in_done_ignored", 64'(busy), 64'd0);
      tick();
      check("req_in_done_still_idle", 64'(recov_valid), 64'd0);

      // Randomly stalled recovery with illegal retires thrown in.
      recover_req = 1'b1;
      tick();
      recover_req = 1'b0;
      hs = 0; guard = 0; stalled = 1'b0; prev_base = '0; prev_tags = '0;
      while (!recov_done && guard < 200) begin
         if (recov_valid && hs < N_BEATS) begin
            check("stall_base", 64'(recov_base), 64'(hs * RECOV_W));
            check("stall_tags", 64'(recov_tags), 64'(model_beat(hs)));
            if (stalled) begin
               check("stall_base_hold", 64'(recov_base), 64'(prev_base));
               check("stall_tags_hold", 64'(recov_tags), 64'(prev_tags));
            end
         end
         prev_base = recov_base;
         prev_tags = recov_tags;
         recov_ready = ($urandom_range(0, 9) < 6);
         random_bundle();
         drive_bundle();
         v_before = recov_valid;
         stalled = v_before && !recov_ready;
         tick();
         if (v_before && recov_ready) begin
            $display("[TB] handshake %0d base=%0d", hs, prev_base);
            hs++;
         end
         check("busy_free_valid", 64'(free_valid), 64'd0);
         guard++;
      end
      ret_valid = '0;
      recov_ready = 1'b0;
      check("stall_done_seen", 64'(recov_done), 64'd1);
      check("stall_handshakes", 64'(hs), 64'(N_BEATS));
      tick();
      check("stall_idle", 64'(busy), 64'd0);
      check_all_map();

      // Reset in the middle of the stream.
      recover_req = 1'b1;
      recov_ready = 1'b1;
      tick();
      recover_req = 1'b0;
      tick();
      tick();
      check("mid_base2", 64'(recov_base), 64'(2 * RECOV_W));
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(recov_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_base", 64'(recov_base), 64'd0);
      check("mid_rst_done", 64'(recov_done), 64'd0);
      model_reset();
      for (int n = 0; n < 3; n++) begin
         tick();
         check("mid_rst_no_done", 64'(recov_done), 64'd0);
      end
      reset = 1'b1;
      recov_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         check("post_rst_no_done", 64'(recov_done), 64'd0);
         check("post_rst_idle", 64'(busy), 64'd0);
      end
      check_all_map();
      $display("[TB] reset-during-recovery checked");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
